// File: rtl/sys_reset_seq_if.sv
// ---------------------------------------------------------------------------
// sys_reset_seq_if
//   Signal bundle between the PLL/board side and the reset sequencer.
//   master : drives locked_i and hb_mode_i, observes the sequencer outputs.
//   slave  : the sequencer itself.
//   Signals:
//     locked_i     PLL lock indication (asynchronous to the system clock)
//     hb_mode_i    heartbeat mode, 0 = square blink, 1 = double pulse
//     nreset_o     active-low staged resets, bit 0 released first
//     ready_o      all stages released
//     heartbeat_o  LED drive
//     lock_lost_o  sticky lock-loss flag
//     relock_cnt_o saturating count of lock-loss events
// ---------------------------------------------------------------------------
interface sys_reset_seq_if #(
  parameter int unsigned N_STAGES = 4
);
  logic                locked_i;
  logic                hb_mode_i;
  logic [N_STAGES-1:0] nreset_o;
  logic                ready_o;
  logic                heartbeat_o;
  logic                lock_lost_o;
  logic [7:0]          relock_cnt_o;

  modport master (
    output locked_i, hb_mode_i,
    input  nreset_o, ready_o, heartbeat_o, lock_lost_o, relock_cnt_o
  );

  modport slave (
    input  locked_i, hb_mode_i,
    output nreset_o, ready_o, heartbeat_o, lock_lost_o, relock_cnt_o
  );
endinterface

// File: rtl/sys_reset_seq.sv
// ---------------------------------------------------------------------------
// sys_reset_seq
//   Sits after the PLL. Waits for a filtered, stable lock, then releases
//   N_STAGES active-low reset domains one by one, STAGE_DLY cycles apart.
//   Any lock loss after sequencing began drops every stage at once, records
//   the event and starts over. While fully released, a heartbeat LED blinks
//   as a square wave or a double pulse.
//   Ports:
//     clk_i    system clock (PLL c0)
//     reset_i  synchronous, active-high reset
//     bus      sys_reset_seq_if.slave (lock/mode in, resets/status out)
//   The N_STAGES parameter must match the one of the connected interface.
// ---------------------------------------------------------------------------
module sys_reset_seq #(
  parameter int unsigned N_STAGES  = 4,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned STAGE_DLY = 1024,
  parameter int unsigned HB_DIV    = 25000000
) (
  input logic             clk_i,
  input logic             reset_i,
  sys_reset_seq_if.slave  bus
);

  // One counter serves both the lock filter and the inter-stage gap, so it
  // is sized for the larger of the two terminal counts.
  localparam int unsigned CNT_MAX = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
  localparam int unsigned CNT_W   = (CNT_MAX  > 1) ? $clog2(CNT_MAX)  : 1;
  localparam int unsigned STG_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int unsigned SLOT_W  = (HB_DIV   > 1) ? $clog2(HB_DIV)   : 1;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SEQ  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state;
  logic                lk_meta;
  logic                lk;
  logic [CNT_W-1:0]    cnt;
  logic [STG_W-1:0]    stage;
  logic [SLOT_W-1:0]   slot;
  logic [2:0]          phase;
  logic [N_STAGES-1:0] nreset_q;
  logic                ready_q;
  logic                hb_q;
  logic                lost_q;
  logic [7:0]          relock_q;

  assign bus.nreset_o     = nreset_q;
  assign bus.ready_o      = ready_q;
  assign bus.heartbeat_o  = hb_q;
  assign bus.lock_lost_o  = lost_q;
  assign bus.relock_cnt_o = relock_q;

  // NOTE: every register here is written with <= so all of them update
  // together from pre-edge values; mixing in = would make the result depend
  // on statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lk_meta  <= 1'b0;
      lk       <= 1'b0;
      state    <= HOLD;
      cnt      <= '0;
      stage    <= '0;
      slot     <= '0;
      phase    <= '0;
      nreset_q <= '0;
      ready_q  <= 1'b0;
      hb_q     <= 1'b0;
      lost_q   <= 1'b0;
      relock_q <= '0;
    end else begin
      // Two-flop synchronizer; lk is the only lock signal the FSM looks at.
      lk_meta <= bus.locked_i;
      lk      <= lk_meta;

      if ((state != HOLD) && !lk) begin
        // Lock lost once sequencing has begun: drop everything, start over.
        state    <= HOLD;
        cnt      <= '0;
        stage    <= '0;
        slot     <= '0;
        phase    <= '0;
        nreset_q <= '0;
        ready_q  <= 1'b0;
        hb_q     <= 1'b0;
        lost_q   <= 1'b1;
        if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
      end else begin
        case (state)
          HOLD: begin
            nreset_q <= '0;
            ready_q  <= 1'b0;
            hb_q     <= 1'b0;
            slot     <= '0;
            phase    <= '0;
            if (!lk) begin
              cnt <= '0;
            end else if (cnt == CNT_W'(LOCK_FILT - 1)) begin
              state <= SEQ;
              cnt   <= '0;
              stage <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          SEQ: begin
            if (cnt == CNT_W'(STAGE_DLY - 1)) begin
              nreset_q[stage] <= 1'b1;
              cnt             <= '0;
              if (stage == STG_W'(N_STAGES - 1)) begin
                // Last stage: ready rises on the same edge as its release.
                // stage is left at the last index; it is cleared on HOLD entry.
                state   <= RUN;
                ready_q <= 1'b1;
              end else begin
                stage <= stage + STG_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          RUN: begin
            if (slot == SLOT_W'(HB_DIV - 1)) begin
              slot  <= '0;
              phase <= phase + 3'd1;
            end else begin
              slot <= slot + SLOT_W'(1);
            end
            // Decode of the phase held before this edge, so the LED lags
            // the phase counter by one cycle. Mode is not synchronized:
            // it is a quasi-static debug strap.
            hb_q <= bus.hb_mode_i ? ((phase == 3'd1) || (phase == 3'd3))
                                  : phase[0];
          end

          default: begin
            state <= HOLD;
          end
        endcase
      end
    end
  end

endmodule
